// File: rtl/act_window_buffer_pkg.sv
// act_buf_pkg: shared definitions for the 3x3 activation window generator.
//   KSIZE      - kernel edge length (window is KSIZE x KSIZE)
//   state_t    - row sequencer states
//   n_patches  - number of patches a row produces for a given width/pad/stride
package act_buf_pkg;

    localparam int KSIZE = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PAD_L = 3'd1,
        FILL  = 3'd2,
        RUN   = 3'd3,
        PAD_R = 3'd4,
        DRAIN = 3'd5
    } state_t;

    // Patches in a row: floor((width + 2*pad - KSIZE) / stride) + 1.
    // The caller guarantees width + 2*pad >= KSIZE.
    function automatic logic [15:0] n_patches(input logic [15:0] width,
                                              input logic        pad,
                                              input logic        stride);
        logic [15:0] span;
        span = width + {14'd0, pad, 1'b0} - 16'(KSIZE);
        return stride ? (span >> 1) + 16'd1 : span + 16'd1;
    endfunction

endpackage

// File: rtl/act_window_ch.sv
// act_window_ch: per-channel 3x3 shift window.
// Only the two most recent columns are stored; together with the incoming
// column they form the window as it will look right after a push, which the
// top level captures into its output register.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous clear of the stored columns (row start)
//   push        - shift left by one column, new column enters c2
//   zero_col    - push a zero column instead of col_in (padding)
//   col_in      - {row0, row1, row2} of the incoming column
//   patch_next  - window after a push, row-major, r0c0 in MSBs
module act_window_ch
    import act_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      push,
    input  logic                      zero_col,
    input  logic [3*DATA_WIDTH-1:0]   col_in,
    output logic [9*DATA_WIDTH-1:0]   patch_next
);

    logic [DATA_WIDTH-1:0] hist    [KSIZE][KSIZE-1];
    logic [DATA_WIDTH-1:0] new_col [KSIZE];

    always_comb begin
        for (int r = 0; r < KSIZE; r++) begin
            new_col[r] = zero_col ? '0 : col_in[(KSIZE-1-r)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        patch_next = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE-1; c++) begin
                patch_next[(8 - (r*KSIZE + c))*DATA_WIDTH +: DATA_WIDTH] = hist[r][c];
            end
            patch_next[(8 - (r*KSIZE + 2))*DATA_WIDTH +: DATA_WIDTH] = new_col[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE-1; c++) begin
                    hist[r][c] <= '0;
                end
            end
        end else if (clr) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE-1; c++) begin
                    hist[r][c] <= '0;
                end
            end
        end else if (push) begin
            for (int r = 0; r < KSIZE; r++) begin
                hist[r][0] <= hist[r][1];
                hist[r][1] <= new_col[r];
            end
        end
    end

endmodule

// File: rtl/act_window_buffer.sv
// act_window_buffer: 3x3 activation window generator for all channels.
// Accepts one 3-row column per channel per cycle and emits 3x3 patches with
// runtime width, stride 1/2, optional one-column zero padding and
// valid/ready flow control on both sides.
//   clk, rst_n            - clock, asynchronous active-low reset
//   start, cfg_*          - row start pulse and row configuration
//   in_valid/in_ready     - input column handshake
//   in_row0..2            - top/middle/bottom column data, channel 0 in MSBs
//   out_valid/out_ready   - output patch handshake
//   out_patch, out_last   - patch data (channel 0 in MSBs), final-patch flag
//   busy, err             - row in progress, rejected-start pulse
//
// state | meaning
// IDLE  | waiting for start
// PAD_L | push the left zero column
// FILL  | accepting columns, fewer than KSIZE pushed
// RUN   | accepting columns, patches being produced
// PAD_R | push the right zero column
// DRAIN | take trailing real columns, wait for final patch to be taken
module act_window_buffer
    import act_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CH         = 64,
    parameter int MAX_W      = 224,
    parameter int COL_W      = $clog2(MAX_W + 3)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [COL_W-1:0]             cfg_width,
    input  logic                         cfg_stride,
    input  logic                         cfg_pad,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH*CH-1:0]     in_row0,
    input  logic [DATA_WIDTH*CH-1:0]     in_row1,
    input  logic [DATA_WIDTH*CH-1:0]     in_row2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH*CH*9-1:0]   out_patch,
    output logic                         out_last,
    output logic                         busy,
    output logic                         err
);

    localparam int PW = DATA_WIDTH*CH*9;
    localparam logic [COL_W-1:0] ONE = COL_W'(1);
    localparam logic [COL_W-1:0] KS  = COL_W'(KSIZE);

    state_t             state, state_n;
    logic [COL_W-1:0]   width_r, n_r, push_cnt, acc_cnt, patch_cnt;
    logic               pad_r, stride_r;

    logic               can_push, real_left, push, zero_col, accept;
    logic               start_ok, start_acc, patch_here, patch_final, emit;
    logic [COL_W-1:0]   push_inc, push_off;
    logic [COL_W:0]     span;
    logic [PW-1:0]      patch_next;

    // Real width plus padding must cover one kernel; width itself is bounded.
    assign span      = {1'b0, cfg_width} + {{(COL_W-1){1'b0}}, cfg_pad, 1'b0};
    assign start_ok  = (span >= (COL_W+1)'(KSIZE)) && (cfg_width <= COL_W'(MAX_W));
    assign start_acc = (state == IDLE) && start && start_ok;

    // Any push is held off while an unaccepted patch is pending.
    assign can_push  = !out_valid || out_ready;
    assign real_left = acc_cnt < width_r;

    // Decision whether the push being made this cycle completes a patch.
    assign push_inc    = push_cnt + ONE;
    assign push_off    = push_inc - KS;
    assign patch_here  = (push_inc >= KS) && !(push_off[0] && stride_r) && (patch_cnt < n_r);
    assign patch_final = (patch_cnt + ONE) == n_r;
    assign emit        = push && patch_here;

    assign busy = (state != IDLE);

    always_comb begin
        state_n  = state;
        push     = 1'b0;
        zero_col = 1'b0;
        accept   = 1'b0;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start_acc) begin
                    state_n = cfg_pad ? PAD_L : FILL;
                end
            end
            PAD_L: begin
                if (can_push) begin
                    push     = 1'b1;
                    zero_col = 1'b1;
                    state_n  = FILL;
                end
            end
            FILL, RUN, DRAIN: begin
                if (real_left) begin
                    in_ready = can_push;
                    if (can_push && in_valid) begin
                        push   = 1'b1;
                        accept = 1'b1;
                        if ((acc_cnt + ONE) == width_r) begin
                            state_n = pad_r ? PAD_R : DRAIN;
                        end else if (state == DRAIN) begin
                            state_n = DRAIN;
                        end else if (patch_here && patch_final) begin
                            // remaining real columns cannot complete another patch
                            state_n = DRAIN;
                        end else if (push_inc >= KS) begin
                            state_n = RUN;
                        end else begin
                            state_n = FILL;
                        end
                    end
                end else if (can_push) begin
                    // all columns in and the last patch taken (or being taken)
                    state_n = IDLE;
                end
            end
            PAD_R: begin
                if (can_push) begin
                    push     = 1'b1;
                    zero_col = 1'b1;
                    state_n  = DRAIN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            width_r   <= '0;
            n_r       <= '0;
            pad_r     <= 1'b0;
            stride_r  <= 1'b0;
            push_cnt  <= '0;
            acc_cnt   <= '0;
            patch_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            err   <= (state == IDLE) && start && !start_ok;
            if (start_acc) begin
                width_r   <= cfg_width;
                pad_r     <= cfg_pad;
                stride_r  <= cfg_stride;
                n_r       <= COL_W'(n_patches(16'(cfg_width), cfg_pad, cfg_stride));
                push_cnt  <= '0;
                acc_cnt   <= '0;
                patch_cnt <= '0;
            end else begin
                if (push)   push_cnt  <= push_inc;
                if (accept) acc_cnt   <= acc_cnt + ONE;
                if (emit)   patch_cnt <= patch_cnt + ONE;
            end
        end
    end

    // Output register: a new patch may replace the current one in the same
    // cycle it is accepted, so there is no bubble between patches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_patch <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_last  <= patch_final;
            out_patch <= patch_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        act_window_ch #(.DATA_WIDTH(DATA_WIDTH)) u_win (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (start_acc),
            .push       (push),
            .zero_col   (zero_col),
            .col_in     ({in_row0[(CH-1-g)*DATA_WIDTH +: DATA_WIDTH],
                          in_row1[(CH-1-g)*DATA_WIDTH +: DATA_WIDTH],
                          in_row2[(CH-1-g)*DATA_WIDTH +: DATA_WIDTH]}),
            .patch_next (patch_next[(CH-1-g)*9*DATA_WIDTH +: 9*DATA_WIDTH])
        );
    end

endmodule
